control_sequencer: RTL

Parametrised multi-class microcode sequencer for the 8-bit common-bus datapath. It drives the single shared data bus select and all register load enables. It sequences four instruction classes: register arithmetic, immediate arithmetic, load and conditional branch. Instruction fetch and data loads use a variable-latency memory handshake with a configurable timeout and a sticky fault state.

---
 rtl/control_sequencer_if.sv | 55 +++++
 rtl/control_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Bus select encoding and the control interface between the microcode
// sequencer (master) and the 8-bit common-bus datapath (slave).

package control_sequencer_pkg;
  // Drivers that can own the shared data bus in a given cycle
  typedef enum logic [3:0] {
    ZERO      = 4'd0,
    PC_PLUS_4 = 4'd1,
    IR_R1     = 4'd2,
    IR_R2     = 4'd3,
    IR_RD     = 4'd4,
    RF        = 4'd5,
    ALU_BUS   = 4'd6,
    MEM_RD    = 4'd7,
    BR_TGT    = 4'd8
  } data_bus_t;

  localparam logic [1:0] OP_ARITH_R = 2'b00;
  localparam logic [1:0] OP_ARITH_I = 2'b01;
  localparam logic [1:0] OP_LOAD    = 2'b10;
  localparam logic [1:0] OP_BRANCH  = 2'b11;
endpackage

interface control_sequencer_if;
  logic                            run;
  logic [1:0]                      op_class;
  logic                            alu_zero;
  logic                            mem_ready;
  control_sequencer_pkg::data_bus_t data_bus_sel;
  logic                            pc_load_en;
  logic                            ir_load_en;
  logic                            rf_write_read;
  logic                            alu_src1_load_en;
  logic                            alu_src2_load_en;
  logic                            sel_field_load_en;
  logic                            mar_load_en;
  logic                            mem_req;
  logic                            mem_addr_sel;
  logic                            instr_done;
  logic                            fault;

  modport master (
    input  run, op_class, alu_zero, mem_ready,
    output data_bus_sel, pc_load_en, ir_load_en, rf_write_read,
           alu_src1_load_en, alu_src2_load_en, sel_field_load_en,
           mar_load_en, mem_req, mem_addr_sel, instr_done, fault
  );

  modport slave (
    output run, op_class, alu_zero, mem_ready,
    input  data_bus_sel, pc_load_en, ir_load_en, rf_write_read,
           alu_src1_load_en, alu_src2_load_en, sel_field_load_en,
           mar_load_en, mem_req, mem_addr_sel, instr_done, fault
  );
endinterface

// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit common-bus datapath. Steps register
// arithmetic, immediate arithmetic, load and conditional branch
// instructions, with a timed-out variable-latency memory handshake that
// parks the machine in a sticky FAULT state.

module control_sequencer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1
) (
  input logic                 clock,
  input logic                 reset,
  control_sequencer_if.master bus
);
  import control_sequencer_pkg::*;

  typedef enum logic [3:0] {
    IDLE, FETCH, SEL_R1, RD_R1, SEL_R2, RD_R2, IMM, SEL_RD,
    WB, LD_ADDR, LD_MEM, BR_CHK, PC_INC, FAULT
  } state_t;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
  data_bus_t  busSel_q, busSel_d;
  logic       pcLoad_q, pcLoad_d;
  logic       rfWrite_q, rfWrite_d;
  logic       src1Load_q, src1Load_d;
  logic       src2Load_q, src2Load_d;
  logic       selLoad_q, selLoad_d;
  logic       marLoad_q, marLoad_d;
  logic       memReq_q, memReq_d;
  logic       memAddrSel_q, memAddrSel_d;
  logic       instrDone_q, instrDone_d;
  logic       fault_q, fault_d;
  logic       memWait, timeout, brTaken;

  // Next state, wait counter and the Moore outputs of the state being entered
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = '0;
    busSel_d     = ZERO;
    pcLoad_d     = 1'b0;
    rfWrite_d    = 1'b0;
    src1Load_d   = 1'b0;
    src2Load_d   = 1'b0;
    selLoad_d    = 1'b0;
    marLoad_d    = 1'b0;
    memReq_d     = 1'b0;
    memAddrSel_d = 1'b0;
    instrDone_d  = 1'b0;
    fault_d      = 1'b0;

    memWait = ((state_q == FETCH) || (state_q == LD_MEM)) && !bus.mem_ready;
    timeout = memWait && (WAIT_LIMIT > 0) && (waitCnt_q == CNT_W'(WAIT_LIMIT));
    if (memWait) waitCnt_d = waitCnt_q + CNT_W'(1);

    case (state_q)
      IDLE:    if (bus.run) state_d = FETCH;
      FETCH:   if (bus.mem_ready) state_d = SEL_R1;
               else if (timeout) state_d = FAULT;
      SEL_R1:  state_d = (bus.op_class == OP_LOAD) ? LD_ADDR : RD_R1;
      RD_R1:   state_d = (bus.op_class == OP_ARITH_I) ? IMM : SEL_R2;
      SEL_R2:  state_d = RD_R2;
      RD_R2:   state_d = (bus.op_class == OP_BRANCH) ? BR_CHK : SEL_RD;
      IMM:     state_d = SEL_RD;
      SEL_RD:  state_d = (bus.op_class == OP_LOAD) ? LD_MEM : WB;
      WB:      state_d = PC_INC;
      LD_ADDR: state_d = SEL_RD;
      LD_MEM:  if (bus.mem_ready) state_d = PC_INC;
               else if (timeout) state_d = FAULT;
      BR_CHK:  if (bus.alu_zero) state_d = bus.run ? FETCH : IDLE;
               else state_d = PC_INC;
      PC_INC:  state_d = bus.run ? FETCH : IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase

    case (state_d)
      FETCH:   begin busSel_d = MEM_RD; memReq_d = 1'b1; end
      SEL_R1:  begin busSel_d = IR_R1; selLoad_d = 1'b1; end
      RD_R1:   begin busSel_d = RF; src1Load_d = 1'b1; end
      SEL_R2:  begin busSel_d = IR_R2; selLoad_d = 1'b1; end
      RD_R2:   begin busSel_d = RF; src2Load_d = 1'b1; end
      IMM:     begin busSel_d = IR_R2; src2Load_d = 1'b1; end
      SEL_RD:  begin busSel_d = IR_RD; selLoad_d = 1'b1; end
      WB:      begin busSel_d = ALU_BUS; rfWrite_d = 1'b1; end
      LD_ADDR: begin busSel_d = RF; marLoad_d = 1'b1; end
      LD_MEM:  begin busSel_d = MEM_RD; memReq_d = 1'b1; memAddrSel_d = 1'b1; end
      PC_INC:  begin busSel_d = PC_PLUS_4; pcLoad_d = 1'b1; instrDone_d = 1'b1; end
      FAULT:   fault_d = 1'b1;
      default: ;
    endcase
  end

  // State, wait counter and registered outputs; reset aborts any instruction at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      waitCnt_q    <= '0;
      busSel_q     <= ZERO;
      pcLoad_q     <= 1'b0;
      rfWrite_q    <= 1'b0;
      src1Load_q   <= 1'b0;
      src2Load_q   <= 1'b0;
      selLoad_q    <= 1'b0;
      marLoad_q    <= 1'b0;
      memReq_q     <= 1'b0;
      memAddrSel_q <= 1'b0;
      instrDone_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      busSel_q     <= busSel_d;
      pcLoad_q     <= pcLoad_d;
      rfWrite_q    <= rfWrite_d;
      src1Load_q   <= src1Load_d;
      src2Load_q   <= src2Load_d;
      selLoad_q    <= selLoad_d;
      marLoad_q    <= marLoad_d;
      memReq_q     <= memReq_d;
      memAddrSel_q <= memAddrSel_d;
      instrDone_q  <= instrDone_d;
      fault_q      <= fault_d;
    end
  end

  // A taken branch retires inside BR_CHK because alu_zero is only valid there;
  // IR and RF loads from memory follow mem_ready in the same cycle.
  assign brTaken               = (state_q == BR_CHK) && bus.alu_zero;
  assign bus.data_bus_sel      = brTaken ? BR_TGT : busSel_q;
  assign bus.pc_load_en        = pcLoad_q | brTaken;
  assign bus.instr_done        = instrDone_q | brTaken;
  assign bus.ir_load_en        = (state_q == FETCH) && bus.mem_ready;
  assign bus.rf_write_read     = rfWrite_q | ((state_q == LD_MEM) && bus.mem_ready);
  assign bus.alu_src1_load_en  = src1Load_q;
  assign bus.alu_src2_load_en  = src2Load_q;
  assign bus.sel_field_load_en = selLoad_q;
  assign bus.mar_load_en       = marLoad_q;
  assign bus.mem_req           = memReq_q;
  assign bus.mem_addr_sel      = memAddrSel_q;
  assign bus.fault             = fault_q;

endmodule
